// File: rtl/sprite_pkg.sv
// Shared types, screen constants and the sprite ROM address helper.
package sprite_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Row-major address inside a sprite bitmap; a mirrored sprite reads its columns right to left.
    function automatic int unsigned sprite_rom_addr(
        input int unsigned row,
        input int unsigned col,
        input logic        hflip,
        input int unsigned width
    );
        int unsigned c;
        c = hflip ? (width - 1 - col) : col;
        return row * width + c;
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// Per-sprite stage-0 logic: decides whether the current pixel lies inside
// the sprite box and, if so, which ROM word holds its colour.
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int SPR_W = 40,
    parameter int SPR_H = 50,
    parameter int AW    = 11
) (
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          en,
    input  logic          hflip,
    output logic          hit,
    output logic [AW-1:0] addr
);

    // One extra bit keeps x + SPR_W from wrapping back to the left edge.
    logic [10:0] px, py, x0, y0, x1, y1;
    logic        in_x, in_y, on_screen;

    assign px = {1'b0, draw_x};
    assign py = {1'b0, draw_y};
    assign x0 = {1'b0, x};
    assign y0 = {1'b0, y};
    assign x1 = x0 + 11'(SPR_W);
    assign y1 = y0 + 11'(SPR_H);

    assign in_x      = (px >= x0) && (px < x1);
    assign in_y      = (py >= y0) && (py < y1);
    assign on_screen = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
    assign hit       = en && in_x && in_y && on_screen;

    // Address is only meaningful on a hit; otherwise park it at zero.
    always_comb begin
        addr = '0;
        if (hit) begin
            addr = AW'(sprite_rom_addr(32'(py - y0), 32'(px - x0), hflip, SPR_W));
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: overlays N_SPR ROM-backed sprites on a background
// stream with a fixed three-cycle latency and reports per-frame collisions.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int     N_SPR = 4,
    parameter int     SPR_W = 40,
    parameter int     SPR_H = 50,
    parameter int     AW    = 11,
    parameter rgb12_t KEY   = 12'h000
) (
    input  logic                       vga_clk,
    input  logic                       reset,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank,
    input  logic [N_SPR-1:0][9:0]      spr_x,
    input  logic [N_SPR-1:0][9:0]      spr_y,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR-1:0]           spr_hflip,
    output logic [N_SPR-1:0][AW-1:0]   rom_addr,
    input  logic [N_SPR-1:0][11:0]     rom_data,
    input  logic [11:0]                bg_rgb,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue,
    output logic [N_SPR-1:0]           collision
);

    logic [N_SPR-1:0]         hit_s0, hit_s1, hit_s2;
    logic [N_SPR-1:0][AW-1:0] addr_s0;
    logic                     frame_s0, frame_s1, frame_s2;
    logic                     blank_s1, blank_s2;
    logic [N_SPR-1:0]         opaque, overlap, acc;
    logic [3:0]               n_opaque;
    rgb12_t                   winner, pix_s2;

    for (genvar g = 0; g < N_SPR; g++) begin : g_spr
        sprite_hit_addr #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .AW    (AW)
        ) u_hit_addr (
            .draw_x (DrawX),
            .draw_y (DrawY),
            .x      (spr_x[g]),
            .y      (spr_y[g]),
            .en     (spr_en[g]),
            .hflip  (spr_hflip[g]),
            .hit    (hit_s0[g]),
            .addr   (addr_s0[g])
        );
    end

    assign frame_s0 = (DrawX == 10'd0) && (DrawY == 10'd0);

    // S1/S2: register ROM addresses, then carry hit/blank/frame along until rom_data arrives.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr <= '0;
            hit_s1   <= '0;
            hit_s2   <= '0;
            blank_s1 <= 1'b0;
            blank_s2 <= 1'b0;
            frame_s1 <= 1'b0;
            frame_s2 <= 1'b0;
        end else begin
            rom_addr <= addr_s0;
            hit_s1   <= hit_s0;
            hit_s2   <= hit_s1;
            blank_s1 <= blank;
            blank_s2 <= blank_s1;
            frame_s1 <= frame_s0;
            frame_s2 <= frame_s1;
        end
    end

    // Priority select: scanning from the top index down leaves the lowest opaque sprite as winner.
    always_comb begin
        opaque   = '0;
        n_opaque = '0;
        winner   = bg_rgb;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_s2[i] && (rom_data[i] != KEY)) begin
                opaque[i] = 1'b1;
                n_opaque  = n_opaque + 4'd1;
                winner    = rom_data[i];
            end
        end
        pix_s2  = blank_s2 ? winner : '0;
        overlap = (blank_s2 && (n_opaque >= 4'd2)) ? opaque : '0;
    end

    // S3: output pixel, collision accumulation, and frame-boundary hand-off of the accumulator.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            acc       <= '0;
            collision <= '0;
        end else begin
            {red, green, blue} <= pix_s2;
            if (frame_s2) begin
                collision <= acc;
                acc       <= overlap;
            end else begin
                acc <= acc | overlap;
            end
        end
    end

endmodule
